// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
// Instruction-fetch front end for the 5-stage RV64 pipeline. It keeps the
// fetch PC and issues word requests to instruction memory over a valid/ready
// handshake. In-order responses fill a small prefetch queue, and the queue
// head is presented to decode. Decode can stall the output, and a taken
// branch or jump redirect from execute flushes the queue.
//
// Ports
//   clk, rst_n        clock (posedge) and asynchronous active-low reset
//   imem_req_valid    request to instruction memory
//   imem_req_ready    memory accepts the request this cycle
//   imem_req_addr     word-aligned request address (current fetch PC)
//   imem_rsp_valid    in-order response strobe
//   imem_rsp_data     instruction word of the response
//   stall             decode load-use stall; hold the presented instruction
//   br_redirect       taken branch/jump; flush and refetch from br_target
//   br_target         redirect target (bits [1:0] ignored)
//   if_valid          if_pc/if_instr carry a real instruction
//   if_pc, if_instr   presented instruction (0 / NOP_INSTR when not valid)
module fetch_prefetch_unit #(
   parameter logic [63:0] RESET_PC  = 64'd0,
   parameter int          DEPTH     = 4,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        stall,
   input  logic        br_redirect,
   input  logic [63:0] br_target,
   output logic        if_valid,
   output logic [63:0] if_pc,
   output logic [31:0] if_instr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [63:0]   fetch_pc;
   logic [63:0]   q_pc    [DEPTH];
   logic [31:0]   q_instr [DEPTH];
   logic [AW-1:0] head;         // oldest allocated slot
   logic [AW-1:0] tail;         // next slot to allocate
   logic [AW-1:0] fptr;         // next slot a response fills
   logic [CW-1:0] occ;          // allocated slots, filled or not
   logic [CW-1:0] unf;          // allocated but not yet filled
   logic [CW-1:0] discard_cnt;  // stale responses still to be dropped

   logic          req_fire;
   logic          rsp_fill;
   logic          rsp_drop;
   logic          head_vld;
   logic          pop;
   logic [63:0]   redirect_pc;

   // Clamp a widened count back into the discard counter range.
   function automatic logic [CW-1:0] sat_cnt(input logic [CW:0] v);
      return v[CW] ? {CW{1'b1}} : v[CW-1:0];
   endfunction

   // Stale responses after a flush: everything still unfilled plus whatever
   // was already pending, less a response consumed in the flush cycle itself.
   function automatic logic [CW-1:0] next_discard(input logic [CW-1:0] pend,
                                                  input logic [CW-1:0] unfilled,
                                                  input logic          rsp);
      logic [CW:0] sum;
      sum = {1'b0, pend} + {1'b0, unfilled};
      if (rsp && (sum != '0)) sum = sum - (CW+1)'(1);
      return sat_cnt(sum);
   endfunction

   assign redirect_pc    = br_target & ~64'd3;

   // Gating with rst_n keeps the request quiet during reset while allowing
   // the first request in the very first clock after release.
   assign imem_req_valid = rst_n && !br_redirect && (occ < CW'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses in a redirect cycle or while discards are pending never fill.
   assign rsp_fill = imem_rsp_valid && !br_redirect && (discard_cnt == '0) && (unf != '0);
   assign rsp_drop = imem_rsp_valid && !br_redirect && (discard_cnt != '0);

   // Slots fill in allocation order, so the head is filled whenever any
   // allocated slot is filled.
   assign head_vld = (occ != unf);
   assign pop      = head_vld && !stall && !br_redirect;

   assign if_valid = head_vld;
   assign if_pc    = head_vld ? q_pc[head]    : 64'd0;
   assign if_instr = head_vld ? q_instr[head] : NOP_INSTR;

   // ---- control state: fetch PC, queue pointers/counters, discard count ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         head        <= '0;
         tail        <= '0;
         fptr        <= '0;
         occ         <= '0;
         unf         <= '0;
         discard_cnt <= '0;
      end else if (br_redirect) begin
         fetch_pc    <= redirect_pc;
         head        <= '0;
         tail        <= '0;
         fptr        <= '0;
         occ         <= '0;
         unf         <= '0;
         discard_cnt <= next_discard(discard_cnt, unf, imem_rsp_valid);
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 64'd4;
            tail     <= tail + AW'(1);
         end
         if (rsp_fill) fptr <= fptr + AW'(1);
         if (pop)      head <= head + AW'(1);
         occ <= occ + CW'(req_fire) - CW'(pop);
         unf <= unf + CW'(req_fire) - CW'(rsp_fill);
         if (rsp_drop) discard_cnt <= discard_cnt - CW'(1);
      end
   end

   // ---- queue payload: written on allocate (pc) and on fill (instr) ----
   always_ff @(posedge clk) begin
      if (req_fire) q_pc[tail]    <= fetch_pc;
      if (rsp_fill) q_instr[fptr] <= imem_rsp_data;
   end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction-fetch front end feeding the IF/ID register of the 5-stage 64-bit RISC-V pipeline.
- Keeps a 64-bit fetch PC and issues word requests to instruction memory through a valid/ready handshake.
- Memory responses return in order with variable latency; they land in a small in-order prefetch queue.
- Presents {pc, instr} to decode, holds on load-use stall, and flushes on a taken-branch/jump redirect from execute.

Parameters:
RESET_PC, 64'd0, fetch address after reset
DEPTH, 4, prefetch queue slots (power of 2, >=2); bounds outstanding plus buffered instructions
NOP_INSTR, 32'h00000013, value driven on if_instr when if_valid=0

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  request to instruction memory
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  64  word address of request (bits[1:0]=0)
imem_rsp_valid  in  1  response data valid, in request order
imem_rsp_data  in  32  instruction word
stall  in  1  decode load-use stall; hold IF/ID output
br_redirect  in  1  taken branch/jump from execute
br_target  in  64  redirect target; bits[1:0] ignored (forced 0)
if_valid  out  1  if_pc/if_instr hold a real instruction
if_pc  out  64  PC of presented instruction
if_instr  out  32  presented instruction

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; queue empty; discard_cnt=0.
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - if_valid=0, if_pc=0, if_instr=NOP_INSTR.
  - First request is possible in the first clock after rst_n rises.
- Queue slot: {pc, instr, filled}.
  - A slot is allocated when a request handshakes (imem_req_valid&&imem_req_ready). It stores pc=imem_req_addr with filled=0.
  - A slot is filled in allocation order when an imem_rsp_valid response is accepted.
  - occupancy = allocated slots, filled or not.
- Request:
  - imem_req_valid = !br_redirect && occupancy<DEPTH; imem_req_addr = fetch_pc.
  - On handshake, fetch_pc += 4 (64-bit wrap).
  - Addr and valid must stay stable while valid=1 and ready=0, except that a redirect drops valid.
- Output (combinational from the queue head):
  - if_valid = head allocated && head filled; if_pc/if_instr = head fields.
  - When if_valid=0: if_pc=0, if_instr=NOP_INSTR.
- Pop: head is removed when if_valid && !stall && !br_redirect.
- Same-cycle events: push, fill and pop may all occur in one cycle. A full queue with a pop does not admit a request that same cycle; imem_req_valid uses pre-pop occupancy.
- Bypass: a response filling an empty head becomes visible on the next cycle. There is no same-cycle bypass, so response-to-if_valid latency is 1 clk.
- Redirect (highest priority, overrides stall):
  - All slots are cleared and fetch_pc <= {br_target[63:2],2'b00}.
  - discard_cnt <= (allocated-unfilled slots) + discard_cnt − (1 if a response arrives this cycle).
  - Any response arriving in the redirect cycle is dropped.
  - No request is issued in the redirect cycle; the target request goes out the next cycle.
- Discard: while discard_cnt>0, each imem_rsp_valid is dropped and discard_cnt decrements. Discarded responses never fill a slot.
- Counter width:
  - discard_cnt is clog2(DEPTH)+1 bits.
  - occupancy + discard_cnt never exceeds 2*DEPTH.
  - New requests after a redirect are allowed while discards are still pending.
- Stall:
  - Output holds while stall=1 and no redirect.
  - Fetch continues filling the queue until occupancy=DEPTH.
- Protocol error: imem_rsp_valid with no unfilled slot and discard_cnt=0 is ignored; the bench flags it as a protocol error.

Test Plan:
- Reset release, memory ready=1 with 1-cycle response latency:
  - Required: request addresses 0,4,8,… on consecutive clocks.
  - Required: if_pc sequence 0,4,8 with the matching instr, one per clock, after a 2-clk initial latency.
- stall=1 for 6 clocks with if_pc=8:
  - Required: if_pc/if_instr held at 8.
  - Required: exactly DEPTH=4 slots allocated, then imem_req_valid=0 with addr=24.
  - After stall drops: 8,12,16,20,24 flow out with no gap.
- Response latency 3, redirect to br_target=0x103 while 2 requests are unfilled:
  - Required: next request addr=0x100.
  - Required: the 2 stale responses are dropped.
  - Required: first if_valid shows pc=0x100.
- Redirect and stall asserted in the same cycle:
  - Required: redirect wins, the queue is flushed, and if_valid=0 the next cycle.
- imem_req_ready=0 for 5 clocks:
  - Required: imem_req_valid=1 with addr stable at the current fetch_pc.
  - Required: queue drains, then if_valid=0 with if_instr=0x00000013.
- rst_n pulsed low mid-stream with responses in flight:
  - Required: outputs reset immediately (asynchronously).
  - Required: after release, fetch restarts at RESET_PC with discard_cnt=0.
